// File: rtl/err_rsp_collect_if.sv
// Producer-channel handshake and firmware read port of the error-response collector.
// Signal names are taken from the collector's side: i_* flow into it, o_* flow out of it.
interface err_rsp_collect_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]        i_ch_valid;
    logic [NUM_CH*DATA_W-1:0] i_ch_data;
    logic [NUM_CH-1:0]        o_ch_ready;
    logic                     i_fw_rd_req;
    logic [DATA_W-1:0]        o_fw_rd_data;
    logic [CH_W-1:0]          o_fw_rd_ch;
    logic                     o_fw_rd_done;

    modport master (
        output i_ch_valid, i_ch_data, i_fw_rd_req,
        input  o_ch_ready, o_fw_rd_data, o_fw_rd_ch, o_fw_rd_done
    );

    modport slave (
        input  i_ch_valid, i_ch_data, i_fw_rd_req,
        output o_ch_ready, o_fw_rd_data, o_fw_rd_ch, o_fw_rd_done
    );
endinterface

// File: rtl/err_rsp_collect.sv
// Collects error responses from NUM_CH producers via round-robin arbitration into a
// first-word fall-through FIFO that firmware drains; also counts backpressured cycles.
module err_rsp_collect #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int NUM_CH    = 4,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    err_rsp_collect_if.slave             bus,
    output logic                         o_fifo_full,
    output logic                         o_fifo_empty,
    output logic                         o_fifo_almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_level,
    output logic [15:0]                  o_stall_cnt,
    input  logic                         i_stall_clr
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = CH_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  grant_idx, cand;
    logic             grant_vld;
    logic             push, pop;
    logic [ENT_W-1:0] head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Scan channels starting at rr_ptr; the first valid one found wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!grant_vld && bus.i_ch_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Ready ignores a same-cycle pop: a full FIFO never accepts, even while draining.
    assign push = grant_vld && !o_fifo_full && !i_reset;
    assign pop  = bus.i_fw_rd_req && !o_fifo_empty;

    assign bus.o_ch_ready = push ? (NUM_CH'(1) << grant_idx) : '0;

    assign o_fifo_empty       = (o_fifo_level == '0);
    assign o_fifo_full        = (o_fifo_level == LVL_W'(DEPTH));
    assign o_fifo_almost_full = (o_fifo_level >= LVL_W'(AF_THRESH));

    assign head             = mem[rd_ptr];
    assign bus.o_fw_rd_data = o_fifo_empty ? '0 : head[DATA_W-1:0];
    assign bus.o_fw_rd_ch   = o_fifo_empty ? '0 : head[DATA_W +: CH_W];

    // NOTE: storage has no reset; the pointers and level alone decide which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {grant_idx, bus.i_ch_data[int'(grant_idx)*DATA_W +: DATA_W]};
        end
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            o_fifo_level     <= '0;
            rr_ptr           <= '0;
            bus.o_fw_rd_done <= 1'b0;
            o_stall_cnt      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
                rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   o_fifo_level <= o_fifo_level + LVL_W'(1);
                2'b01:   o_fifo_level <= o_fifo_level - LVL_W'(1);
                default: o_fifo_level <= o_fifo_level;
            endcase
            bus.o_fw_rd_done <= pop;
            if (i_stall_clr) begin
                o_stall_cnt <= '0;
            end else if (|bus.i_ch_valid && o_fifo_full && o_stall_cnt != 16'hFFFF) begin
                o_stall_cnt <= o_stall_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_err_rsp_collect.sv
// Directed self-checking bench for err_rsp_collect (DATA_W=32, DEPTH=8, NUM_CH=4).
module tb_err_rsp_collect;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall_clr;
    logic        full, empty, af;
    logic [3:0]  level;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    logic [33:0] q[$];
    int          seq [4];

    err_rsp_collect_if #(.DATA_W(32), .NUM_CH(4)) bus ();

    err_rsp_collect #(.DATA_W(32), .DEPTH(8), .NUM_CH(4)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .bus                (bus.slave),
        .o_fifo_full        (full),
        .o_fifo_empty       (empty),
        .o_fifo_almost_full (af),
        .o_fifo_level       (level),
        .o_stall_cnt        (stall_cnt),
        .i_stall_clr        (stall_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ch_word(input int n);
        return 32'h1000_0000 * (n + 1) + 32'(seq[n]);
    endfunction

    task automatic set_ch(input int n);
        bus.i_ch_data[n*32 +: 32] = ch_word(n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_ch_valid = 4'hF;
        cyc();
        cyc();
        if (bus.o_ch_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", bus.o_ch_ready); end
        checks++;
        if (level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++;
        if ({empty, full, af} !== 3'b100) begin errors++; $display("FAIL reset_status: got e/f/af=%b want 100", {empty, full, af}); end
        checks++;
        if (stall_cnt !== 16'd0 || bus.o_fw_rd_done !== 1'b0) begin
            errors++; $display("FAIL reset_cnt_done: got stall=%0d done=%b want 0/0", stall_cnt, bus.o_fw_rd_done);
        end
        checks++;
        if (bus.o_fw_rd_data !== 32'd0 || bus.o_fw_rd_ch !== 2'd0) begin
            errors++; $display("FAIL reset_rd_data: got %h/%0d want 0/0", bus.o_fw_rd_data, bus.o_fw_rd_ch);
        end
        checks++;
        bus.i_ch_valid = 4'h0;
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        bus.i_ch_data[31:0] = 32'hA5A5_0001;
        bus.i_ch_valid = 4'b0001;
        #1;
        if (bus.o_ch_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", bus.o_ch_ready); end
        checks++;
        cyc();
        bus.i_ch_valid = 4'b0000;
        if (level !== 4'd1 || empty !== 1'b0) begin errors++; $display("FAIL single_level: got lvl=%0d empty=%b want 1/0", level, empty); end
        checks++;
        if (bus.o_fw_rd_data !== 32'hA5A5_0001 || bus.o_fw_rd_ch !== 2'd0) begin
            errors++; $display("FAIL single_head: got %h/%0d want a5a50001/0", bus.o_fw_rd_data, bus.o_fw_rd_ch);
        end
        checks++;
        bus.i_fw_rd_req = 1'b1;
        cyc();
        bus.i_fw_rd_req = 1'b0;
        if (bus.o_fw_rd_done !== 1'b1 || empty !== 1'b1) begin
            errors++; $display("FAIL single_pop: got done=%b empty=%b want 1/1", bus.o_fw_rd_done, empty);
        end
        checks++;
        if (bus.o_fw_rd_data !== 32'd0) begin errors++; $display("FAIL single_empty_data: got %h want 0", bus.o_fw_rd_data); end
        checks++;
        cyc();
        if (bus.o_fw_rd_done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", bus.o_fw_rd_done); end
        checks++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int n = 0; n < 4; n++) begin seq[n] = 0; set_ch(n); end
        bus.i_ch_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            int exp_ch;
            exp_ch = k % 4;
            #1;
            if (bus.o_ch_ready !== (4'b0001 << exp_ch)) begin
                errors++; $display("FAIL rr_grant%0d: got %b want ch%0d", k, bus.o_ch_ready, exp_ch);
            end
            checks++;
            q.push_back({2'(exp_ch), ch_word(exp_ch)});
            cyc();
            seq[exp_ch]++;
            set_ch(exp_ch);
            if (level !== 4'(k + 1)) begin errors++; $display("FAIL rr_level%0d: got %0d want %0d", k, level, k + 1); end
            checks++;
            if (af !== (k + 1 >= 6)) begin errors++; $display("FAIL rr_af%0d: got %b want %b", k, af, (k + 1 >= 6)); end
            checks++;
        end
        #1;
        if (full !== 1'b1 || bus.o_ch_ready !== 4'b0000) begin
            errors++; $display("FAIL rr_full: got full=%b ready=%b want 1/0000", full, bus.o_ch_ready);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rr_stall0: got %0d want 0", stall_cnt); end
        checks++;
        for (int s = 1; s <= 3; s++) begin
            cyc();
            if (stall_cnt !== 16'(s)) begin errors++; $display("FAIL rr_stall%0d: got %0d want %0d", s, stall_cnt, s); end
            checks++;
        end
    endtask

    task automatic test_full_pop();
        bus.i_fw_rd_req = 1'b1;
        #1;
        if (bus.o_ch_ready !== 4'b0000) begin errors++; $display("FAIL fp_ready_full: got %b want 0000", bus.o_ch_ready); end
        checks++;
        if ({bus.o_fw_rd_ch, bus.o_fw_rd_data} !== q[0]) begin
            errors++; $display("FAIL fp_head: got %0d/%h want %0d/%h", bus.o_fw_rd_ch, bus.o_fw_rd_data, q[0][33:32], q[0][31:0]);
        end
        checks++;
        cyc();
        bus.i_fw_rd_req = 1'b0;
        void'(q.pop_front());
        if (level !== 4'd7 || bus.o_fw_rd_done !== 1'b1) begin
            errors++; $display("FAIL fp_level7: got lvl=%0d done=%b want 7/1", level, bus.o_fw_rd_done);
        end
        checks++;
        #1;
        if (bus.o_ch_ready !== 4'b0001) begin errors++; $display("FAIL fp_ready_ch0: got %b want 0001", bus.o_ch_ready); end
        checks++;
        q.push_back({2'd0, ch_word(0)});
        cyc();
        bus.i_ch_valid = 4'h0;
        if (level !== 4'd8) begin errors++; $display("FAIL fp_level8: got %0d want 8", level); end
        checks++;
        bus.i_fw_rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ({bus.o_fw_rd_ch, bus.o_fw_rd_data} !== q[0]) begin
                errors++; $display("FAIL fp_order%0d: got %0d/%h want %0d/%h", i, bus.o_fw_rd_ch, bus.o_fw_rd_data, q[0][33:32], q[0][31:0]);
            end
            checks++;
            cyc();
            void'(q.pop_front());
            if (bus.o_fw_rd_done !== 1'b1) begin errors++; $display("FAIL fp_done%0d: got %b want 1", i, bus.o_fw_rd_done); end
            checks++;
        end
        bus.i_fw_rd_req = 1'b0;
        if (empty !== 1'b1) begin errors++; $display("FAIL fp_drained: got empty=%b want 1", empty); end
        checks++;
        cyc();
        if (bus.o_fw_rd_done !== 1'b0) begin errors++; $display("FAIL fp_done_end: got %b want 0", bus.o_fw_rd_done); end
        checks++;
    endtask

    task automatic test_push_pop_same();
        do_reset();
        bus.i_ch_valid = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            bus.i_ch_data[64 +: 32] = 32'h2200_0000 + 32'(i);
            q.push_back({2'd2, 32'h2200_0000 + 32'(i)});
            cyc();
        end
        bus.i_ch_valid = 4'b0000;
        if (level !== 4'd4) begin errors++; $display("FAIL pp_level_pre: got %0d want 4", level); end
        checks++;
        bus.i_ch_data[32 +: 32] = 32'h1100_0099;
        bus.i_ch_valid = 4'b0010;
        bus.i_fw_rd_req = 1'b1;
        cyc();
        bus.i_ch_valid = 4'b0000;
        bus.i_fw_rd_req = 1'b0;
        if (level !== 4'd4 || bus.o_fw_rd_done !== 1'b1) begin
            errors++; $display("FAIL pp_level: got lvl=%0d done=%b want 4/1", level, bus.o_fw_rd_done);
        end
        checks++;
        if (bus.o_fw_rd_data !== 32'h2200_0001 || bus.o_fw_rd_ch !== 2'd2) begin
            errors++; $display("FAIL pp_head: got %0d/%h want 2/22000001", bus.o_fw_rd_ch, bus.o_fw_rd_data);
        end
        checks++;
    endtask

    task automatic test_pop_empty();
        do_reset();
        bus.i_fw_rd_req = 1'b1;
        cyc();
        bus.i_fw_rd_req = 1'b0;
        if (level !== 4'd0 || empty !== 1'b1 || bus.o_fw_rd_done !== 1'b0) begin
            errors++; $display("FAIL pe_state: got lvl=%0d empty=%b done=%b want 0/1/0", level, empty, bus.o_fw_rd_done);
        end
        checks++;
        cyc();
        if (bus.o_fw_rd_done !== 1'b0) begin errors++; $display("FAIL pe_done: got %b want 0", bus.o_fw_rd_done); end
        checks++;
    endtask

    task automatic test_stall_sat();
        do_reset();
        bus.i_ch_data[31:0] = 32'h0BAD_0000;
        bus.i_ch_valid = 4'b0001;
        repeat (8) cyc();
        if (full !== 1'b1 || stall_cnt !== 16'd0) begin
            errors++; $display("FAIL st_fill: got full=%b stall=%0d want 1/0", full, stall_cnt);
        end
        checks++;
        repeat (65534) cyc();
        if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL st_fffe: got %h want fffe", stall_cnt); end
        checks++;
        cyc();
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL st_ffff: got %h want ffff", stall_cnt); end
        checks++;
        repeat (3) cyc();
        if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL st_sat: got %h want ffff", stall_cnt); end
        checks++;
        stall_clr = 1'b1;
        cyc();
        stall_clr = 1'b0;
        if (stall_cnt !== 16'd0) begin errors++; $display("FAIL st_clr: got %h want 0", stall_cnt); end
        checks++;
        cyc();
        if (stall_cnt !== 16'd1) begin errors++; $display("FAIL st_restart: got %h want 1", stall_cnt); end
        checks++;
        bus.i_ch_valid = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.i_ch_data[32 +: 32] = 32'h3300_0000;
        bus.i_ch_valid = 4'b0010;
        repeat (5) cyc();
        bus.i_ch_valid = 4'b0000;
        if (level !== 4'd5) begin errors++; $display("FAIL rm_level_pre: got %0d want 5", level); end
        checks++;
        bus.i_fw_rd_req = 1'b1;
        bus.i_ch_valid = 4'hF;
        rst = 1'b1;
        #1;
        if (bus.o_ch_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready: got %b want 0000", bus.o_ch_ready); end
        checks++;
        cyc();
        rst = 1'b0;
        bus.i_fw_rd_req = 1'b0;
        if (level !== 4'd0 || empty !== 1'b1 || bus.o_fw_rd_done !== 1'b0) begin
            errors++; $display("FAIL rm_state: got lvl=%0d empty=%b done=%b want 0/1/0", level, empty, bus.o_fw_rd_done);
        end
        checks++;
        #1;
        if (bus.o_ch_ready !== 4'b0001) begin errors++; $display("FAIL rm_rr_ptr: got %b want 0001", bus.o_ch_ready); end
        checks++;
        cyc();
        bus.i_ch_valid = 4'h0;
        if (level !== 4'd1 || bus.o_fw_rd_ch !== 2'd0) begin
            errors++; $display("FAIL rm_first: got lvl=%0d ch=%0d want 1/0", level, bus.o_fw_rd_ch);
        end
        checks++;
    endtask

    initial begin
        rst             = 1'b1;
        stall_clr       = 1'b0;
        bus.i_ch_valid  = '0;
        bus.i_ch_data   = '0;
        bus.i_fw_rd_req = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_pop();
        test_push_pop_same();
        test_pop_empty();
        test_stall_sat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/err_rsp_collect.md
ERR_RSP_COLLECT -- requirements
Module: err_rsp_collect

Interface
REQ-001 SHALL have parameter DATA_W, default 32, error-response word width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries (any value >= 2; not required to be a power of two).
REQ-003 SHALL have parameter NUM_CH, default 4, number of error-response producer channels (>= 1).
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2, almost-full level threshold.
REQ-005 SHALL derive CH_W = max(1, clog2(NUM_CH)) and LVL_W = clog2(DEPTH+1).
REQ-006 i_clk  in  1  single clock; all logic on rising edge.
REQ-007 i_reset  in  1  synchronous, active-high reset.
REQ-008 i_ch_valid  in  NUM_CH  per-channel error response valid.
REQ-009 i_ch_data  in  NUM_CH*DATA_W  per-channel response word; channel n at bits [n*DATA_W +: DATA_W].
REQ-010 o_ch_ready  out  NUM_CH  per-channel accept; at most one bit set.
REQ-011 i_fw_rd_req  in  1  FW read (pop) request.
REQ-012 o_fw_rd_data  out  DATA_W  head-entry word.
REQ-013 o_fw_rd_ch  out  CH_W  source channel of head entry.
REQ-014 o_fw_rd_done  out  1  one-cycle pulse acknowledging an accepted pop.
REQ-015 o_fifo_full, o_fifo_empty, o_fifo_almost_full  out  1 each  FIFO status.
REQ-016 o_fifo_level  out  LVL_W  current entry count.
REQ-017 o_stall_cnt  out  16  saturating count of backpressured cycles.
REQ-018 i_stall_clr  in  1  synchronous clear of o_stall_cnt.

Function
REQ-019 Channel handshake: transfer on i_ch_valid[n] & o_ch_ready[n]; producer SHALL hold valid/data until accepted (no drops).
REQ-020 Arbitration SHALL be round-robin: grant lowest-index valid channel at or after rr_ptr, wrapping; rr_ptr <= granted+1 (mod NUM_CH) after each transfer, unchanged otherwise.
REQ-021 o_ch_ready SHALL be combinational: only granted channel, and only when not full (regardless of same-cycle pop).
REQ-022 One push per cycle max; pushed entry stores {channel index, data}.
REQ-023 Pop accepted when i_fw_rd_req & !o_fifo_empty; pop on empty SHALL be ignored with no o_fw_rd_done.
REQ-024 Read SHALL be first-word fall-through: o_fw_rd_data/o_fw_rd_ch show head combinationally; both SHALL be 0 when empty.
REQ-025 o_fw_rd_done SHALL be registered, asserting the cycle after each accepted pop, for exactly one cycle per pop (back-to-back pops give continuous high).
REQ-026 Write/read pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 Simultaneous push and pop: level unchanged, both pointers advance; push into a non-empty FIFO SHALL not disturb head.
REQ-028 o_fifo_level: +1 push only, -1 pop only; o_fifo_empty = (level==0), o_fifo_full = (level==DEPTH), o_fifo_almost_full = (level>=AF_THRESH); all from registered level.
REQ-029 FIFO order SHALL be strict: entries popped in push order.
REQ-030 o_stall_cnt SHALL increment each cycle with any i_ch_valid bit high and o_fifo_full high, saturating at 16'hFFFF.
REQ-031 i_stall_clr SHALL zero o_stall_cnt next cycle, taking priority over same-cycle increment.

Reset
REQ-032 While i_reset high at clock edge: pointers, level, rr_ptr, o_stall_cnt, o_fw_rd_done SHALL become 0; status outputs empty=1, full=0, almost_full=0.
REQ-033 Storage array SHALL not be reset; reset mid-operation SHALL discard all entries, and no o_fw_rd_done SHALL follow a pop in the reset cycle.
REQ-034 o_ch_ready SHALL be 0 during reset cycles.

Verification
REQ-035 Reset, then ch0 pushes 0xA5A5_0001 -> next cycle level=1, empty=0, rd_data=0xA5A5_0001, rd_ch=0; pop -> rd_done pulses one cycle later, empty=1.
REQ-036 All 4 channels valid continuously, FW idle -> grants ch0,ch1,ch2,ch3,ch0,... ; after 8 pushes full=1, all ready=0, stall_cnt increments 1/cycle; almost_full=1 from level 6.
REQ-037 Full FIFO, pop and channel valid same cycle -> no push that cycle (level 7), push next cycle (level 8); pop order matches push order across pointer wrap.
REQ-038 Level 4, push and pop same cycle -> level stays 4, head advances, rd_done next cycle.
REQ-039 Pop on empty -> no state change, rd_done stays 0; stall_cnt forced to 0xFFFF region saturates, i_stall_clr with concurrent stall -> 0.
REQ-040 Assert i_reset with level 5 and pop pending -> next cycle level=0, empty=1, rd_done=0, rr_ptr=0 (ch0 granted first after release).
